// File: rtl/tile_binner_pkg.sv
// ---------------------------------------------------------------------------
// tile_binner_pkg
//   Shared types and widths for the triangle binning stage and the raster
//   block it feeds.
//   - Fixed-point vertex format: FX_TOTAL_BITS signed, FX_FRAC_BITS fraction.
//   - coord_3d_t     : one screen-space vertex {x, y, z}.
//   - tile_bbox_t    : tile-aligned bounding box in tile coordinates.
//   - binner_state_e : binner control states.
//   - min3 / max3    : signed three-way min/max helpers.
// ---------------------------------------------------------------------------
package tile_binner_pkg;

  localparam int FX_TOTAL_BITS     = 16;
  localparam int FX_FRAC_BITS      = 4;
  localparam int COLOR_BITS        = 24;
  localparam int TILE_COLUMNS_BITS = 6;
  localparam int TILE_ROWS_BITS    = 5;

  typedef logic signed [FX_TOTAL_BITS-1:0] fx_t;

  typedef struct packed {
    fx_t x;
    fx_t y;
    fx_t z;
  } coord_3d_t;

  typedef struct packed {
    logic [TILE_COLUMNS_BITS-1:0] xmin;
    logic [TILE_COLUMNS_BITS-1:0] xmax;
    logic [TILE_ROWS_BITS-1:0]    ymin;
    logic [TILE_ROWS_BITS-1:0]    ymax;
  } tile_bbox_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    EMIT  = 2'd2
  } binner_state_e;

  function automatic fx_t min3(input fx_t a, input fx_t b, input fx_t c);
    fx_t m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic fx_t max3(input fx_t a, input fx_t b, input fx_t c);
    fx_t m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

endpackage

// File: rtl/tile_binner_bbox.sv
// ---------------------------------------------------------------------------
// tri_bbox
//   Purely combinational bounding-box unit for one triangle.
//   Finds the pixel min/max of the three vertices (floor of the fixed-point
//   value), converts them to tile coordinates (floor), decides whether the
//   triangle is culled (entirely off-screen, or zero signed area when
//   CULL_DEGEN is set) and clamps the box to the screen.
//   Ports:
//     v{0,1,2}_{x,y}  in   FX_TOTAL_BITS    signed fixed-point vertex coords
//     xmin_t, xmax_t  out  TILE_COLUMNS_BITS clamped tile column range
//     ymin_t, ymax_t  out  TILE_ROWS_BITS    clamped tile row range
//     cull            out  1                 triangle produces no tile jobs
//   The tile range outputs are meaningful only when cull is low.
// ---------------------------------------------------------------------------
module tri_bbox
  import tile_binner_pkg::*;
#(
  parameter int TILE_SHIFT    = 4,
  parameter int NUM_TILE_COLS = 40,
  parameter int NUM_TILE_ROWS = 30,
  parameter int CULL_DEGEN    = 1
) (
  input  logic [FX_TOTAL_BITS-1:0]     v0_x,
  input  logic [FX_TOTAL_BITS-1:0]     v0_y,
  input  logic [FX_TOTAL_BITS-1:0]     v1_x,
  input  logic [FX_TOTAL_BITS-1:0]     v1_y,
  input  logic [FX_TOTAL_BITS-1:0]     v2_x,
  input  logic [FX_TOTAL_BITS-1:0]     v2_y,
  output logic [TILE_COLUMNS_BITS-1:0] xmin_t,
  output logic [TILE_COLUMNS_BITS-1:0] xmax_t,
  output logic [TILE_ROWS_BITS-1:0]    ymin_t,
  output logic [TILE_ROWS_BITS-1:0]    ymax_t,
  output logic                         cull
);

  localparam int  AREA_BITS = 2 * FX_TOTAL_BITS + 1;
  localparam fx_t ZERO      = '0;
  localparam fx_t COLS      = fx_t'(NUM_TILE_COLS);
  localparam fx_t ROWS      = fx_t'(NUM_TILE_ROWS);
  localparam fx_t COLS_M1   = fx_t'(NUM_TILE_COLS - 1);
  localparam fx_t ROWS_M1   = fx_t'(NUM_TILE_ROWS - 1);

  fx_t x0, y0, x1, y1, x2, y2;
  fx_t fx_xmin, fx_xmax, fx_ymin, fx_ymax;
  fx_t px_xmin, px_xmax, px_ymin, px_ymax;
  fx_t tx_min, tx_max, ty_min, ty_max;

  logic signed [AREA_BITS-1:0] e1x, e1y, e2x, e2y, area;
  logic off_screen;
  logic degenerate;

  assign x0 = fx_t'(v0_x);
  assign y0 = fx_t'(v0_y);
  assign x1 = fx_t'(v1_x);
  assign y1 = fx_t'(v1_y);
  assign x2 = fx_t'(v2_x);
  assign y2 = fx_t'(v2_y);

  // Floor is monotonic, so min/max on the raw fixed-point values and then
  // flooring gives the same result as flooring each vertex first.
  assign fx_xmin = min3(x0, x1, x2);
  assign fx_xmax = max3(x0, x1, x2);
  assign fx_ymin = min3(y0, y1, y2);
  assign fx_ymax = max3(y0, y1, y2);

  // Arithmetic shifts floor toward -inf, so a pixel at x=16 lands in tile 1.
  assign px_xmin = fx_xmin >>> FX_FRAC_BITS;
  assign px_xmax = fx_xmax >>> FX_FRAC_BITS;
  assign px_ymin = fx_ymin >>> FX_FRAC_BITS;
  assign px_ymax = fx_ymax >>> FX_FRAC_BITS;

  assign tx_min = px_xmin >>> TILE_SHIFT;
  assign tx_max = px_xmax >>> TILE_SHIFT;
  assign ty_min = px_ymin >>> TILE_SHIFT;
  assign ty_max = px_ymax >>> TILE_SHIFT;

  assign off_screen = (px_xmax < ZERO) || (px_ymax < ZERO) ||
                      (tx_min >= COLS) || (ty_min >= ROWS);

  // Edge vectors are sign-extended before subtracting so the cross product
  // cannot wrap for any pair of representable vertices.
  assign e1x  = AREA_BITS'(x1) - AREA_BITS'(x0);
  assign e1y  = AREA_BITS'(y1) - AREA_BITS'(y0);
  assign e2x  = AREA_BITS'(x2) - AREA_BITS'(x0);
  assign e2y  = AREA_BITS'(y2) - AREA_BITS'(y0);
  assign area = (e1x * e2y) - (e1y * e2x);

  assign degenerate = (CULL_DEGEN != 0) && (area == '0);
  assign cull       = off_screen || degenerate;

  // Past the cull test the min corner is below the screen limit and the max
  // corner is non-negative, so only one side of each bound needs clamping.
  assign xmin_t = (tx_min < ZERO)    ? '0 : tx_min[TILE_COLUMNS_BITS-1:0];
  assign ymin_t = (ty_min < ZERO)    ? '0 : ty_min[TILE_ROWS_BITS-1:0];
  assign xmax_t = (tx_max > COLS_M1) ? COLS_M1[TILE_COLUMNS_BITS-1:0]
                                     : tx_max[TILE_COLUMNS_BITS-1:0];
  assign ymax_t = (ty_max > ROWS_M1) ? ROWS_M1[TILE_ROWS_BITS-1:0]
                                     : ty_max[TILE_ROWS_BITS-1:0];

endmodule

// File: rtl/tile_binner.sv
// ---------------------------------------------------------------------------
// tile_binner
//   Triangle setup/binning stage in front of raster. Accepts one triangle,
//   computes its screen-clamped tile bounding box and re-issues the triangle
//   once per covered tile (row-major) with tile_x/tile_y attached.
//   Off-screen and zero-area triangles are dropped.
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     vld_in / rdy_in       upstream triangle handshake (rdy_in = idle)
//     v{0,1,2}_{x,y,z}      signed fixed-point vertices
//     color                 triangle color
//     vld_out / rdy_out     tile-job handshake towards raster
//     o_v{0,1,2}_{x,y,z}    registered copy of the accepted vertices
//     color_out             registered copy of the accepted color
//     tile_x, tile_y        tile of the current job
//     busy                  triangle in SETUP or EMIT
//   Timing: accept at edge N; the bounding box is registered at N+1 and the
//   cull/emit decision is taken at N+2, so vld_out (or rdy_in for a culled
//   triangle) is high after edge N+2.
// ---------------------------------------------------------------------------
module tile_binner
  import tile_binner_pkg::*;
#(
  parameter int TILE_SHIFT    = 4,
  parameter int NUM_TILE_COLS = 40,
  parameter int NUM_TILE_ROWS = 30,
  parameter int CULL_DEGEN    = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         vld_in,
  output logic                         rdy_in,
  input  logic [FX_TOTAL_BITS-1:0]     v0_x,
  input  logic [FX_TOTAL_BITS-1:0]     v0_y,
  input  logic [FX_TOTAL_BITS-1:0]     v0_z,
  input  logic [FX_TOTAL_BITS-1:0]     v1_x,
  input  logic [FX_TOTAL_BITS-1:0]     v1_y,
  input  logic [FX_TOTAL_BITS-1:0]     v1_z,
  input  logic [FX_TOTAL_BITS-1:0]     v2_x,
  input  logic [FX_TOTAL_BITS-1:0]     v2_y,
  input  logic [FX_TOTAL_BITS-1:0]     v2_z,
  input  logic [COLOR_BITS-1:0]        color,
  output logic                         vld_out,
  input  logic                         rdy_out,
  output logic [FX_TOTAL_BITS-1:0]     o_v0_x,
  output logic [FX_TOTAL_BITS-1:0]     o_v0_y,
  output logic [FX_TOTAL_BITS-1:0]     o_v0_z,
  output logic [FX_TOTAL_BITS-1:0]     o_v1_x,
  output logic [FX_TOTAL_BITS-1:0]     o_v1_y,
  output logic [FX_TOTAL_BITS-1:0]     o_v1_z,
  output logic [FX_TOTAL_BITS-1:0]     o_v2_x,
  output logic [FX_TOTAL_BITS-1:0]     o_v2_y,
  output logic [FX_TOTAL_BITS-1:0]     o_v2_z,
  output logic [COLOR_BITS-1:0]        color_out,
  output logic [TILE_COLUMNS_BITS-1:0] tile_x,
  output logic [TILE_ROWS_BITS-1:0]    tile_y,
  output logic                         busy
);

  binner_state_e state, state_n;

  coord_3d_t                  vtx_q [3];
  tile_bbox_t                 bbox_q;
  tile_bbox_t                 bbox_d;
  logic                       cull_q;
  logic                       cull_d;
  logic                       setup_phase;
  logic                       last_job;
  logic                       accept;

  logic [TILE_COLUMNS_BITS-1:0] bb_xmin, bb_xmax;
  logic [TILE_ROWS_BITS-1:0]    bb_ymin, bb_ymax;

  // -------------------------------------------------------------------------
  // Bounding box of the latched triangle
  // -------------------------------------------------------------------------
  tri_bbox #(
    .TILE_SHIFT    (TILE_SHIFT),
    .NUM_TILE_COLS (NUM_TILE_COLS),
    .NUM_TILE_ROWS (NUM_TILE_ROWS),
    .CULL_DEGEN    (CULL_DEGEN)
  ) u_bbox (
    .v0_x   (vtx_q[0].x),
    .v0_y   (vtx_q[0].y),
    .v1_x   (vtx_q[1].x),
    .v1_y   (vtx_q[1].y),
    .v2_x   (vtx_q[2].x),
    .v2_y   (vtx_q[2].y),
    .xmin_t (bb_xmin),
    .xmax_t (bb_xmax),
    .ymin_t (bb_ymin),
    .ymax_t (bb_ymax),
    .cull   (cull_d)
  );

  assign bbox_d = '{xmin: bb_xmin, xmax: bb_xmax, ymin: bb_ymin, ymax: bb_ymax};

  // -------------------------------------------------------------------------
  // Control FSM
  // -------------------------------------------------------------------------
  // NOTE: every sequential block uses non-blocking assignments so all
  // registers update from the same pre-edge values, matching the hardware.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  assign last_job = (tile_x == bbox_q.xmax) && (tile_y == bbox_q.ymax);

  // NOTE: each output of this block gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n = state;
    rdy_in  = 1'b0;
    vld_out = 1'b0;
    busy    = 1'b0;
    unique case (state)
      IDLE: begin
        rdy_in = 1'b1;
        if (vld_in) state_n = SETUP;
      end
      SETUP: begin
        busy = 1'b1;
        // Second SETUP cycle acts on the registered box and cull flag.
        if (setup_phase) state_n = cull_q ? IDLE : EMIT;
      end
      EMIT: begin
        busy    = 1'b1;
        vld_out = 1'b1;
        if (rdy_out && last_job) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign accept = (state == IDLE) && vld_in;

  // -------------------------------------------------------------------------
  // Datapath: triangle latch, bounding box register, tile walk
  // -------------------------------------------------------------------------
  // NOTE: vtx_q is a handful of flops rather than a RAM, so it is reset
  // along with everything else to give all-zero outputs out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vtx_q       <= '{default: '0};
      color_out   <= '0;
      bbox_q      <= '0;
      cull_q      <= 1'b0;
      setup_phase <= 1'b0;
      tile_x      <= '0;
      tile_y      <= '0;
    end else begin
      if (accept) begin
        vtx_q[0]  <= '{x: fx_t'(v0_x), y: fx_t'(v0_y), z: fx_t'(v0_z)};
        vtx_q[1]  <= '{x: fx_t'(v1_x), y: fx_t'(v1_y), z: fx_t'(v1_z)};
        vtx_q[2]  <= '{x: fx_t'(v2_x), y: fx_t'(v2_y), z: fx_t'(v2_z)};
        color_out <= color;
      end

      if (state == SETUP) begin
        if (!setup_phase) begin
          // The cross product is the deepest path here, so its result is
          // registered before anything downstream depends on it.
          bbox_q      <= bbox_d;
          cull_q      <= cull_d;
          setup_phase <= 1'b1;
        end else begin
          setup_phase <= 1'b0;
          if (!cull_q) begin
            tile_x <= bbox_q.xmin;
            tile_y <= bbox_q.ymin;
          end
        end
      end

      // Row-major walk; the final handshake leaves tile_x/tile_y on the last
      // tile while the FSM drops back to IDLE.
      if ((state == EMIT) && rdy_out) begin
        if (tile_x < bbox_q.xmax) begin
          tile_x <= tile_x + 1'b1;
        end else if (tile_y < bbox_q.ymax) begin
          tile_x <= bbox_q.xmin;
          tile_y <= tile_y + 1'b1;
        end
      end
    end
  end

  assign o_v0_x = vtx_q[0].x;
  assign o_v0_y = vtx_q[0].y;
  assign o_v0_z = vtx_q[0].z;
  assign o_v1_x = vtx_q[1].x;
  assign o_v1_y = vtx_q[1].y;
  assign o_v1_z = vtx_q[1].z;
  assign o_v2_x = vtx_q[2].x;
  assign o_v2_y = vtx_q[2].y;
  assign o_v2_z = vtx_q[2].z;

endmodule

// File: tb/tb_tile_binner.sv
// ---------------------------------------------------------------------------
// tb_tile_binner
//   Self-checking bench for tile_binner. A table of triangles (pixel coords)
//   with hand-computed tile ranges is applied in a loop; each emitted job is
//   compared against the expected row-major tile sequence. Hand-written
//   sequences cover reset in the middle of EMIT and vld_in while busy.
// ---------------------------------------------------------------------------
module tb_tile_binner;
  import tile_binner_pkg::*;

  logic                         clk = 1'b0;
  logic                         rst_n;
  logic                         vld_in;
  logic                         rdy_in;
  logic [FX_TOTAL_BITS-1:0]     v0_x, v0_y, v0_z, v1_x, v1_y, v1_z, v2_x, v2_y, v2_z;
  logic [COLOR_BITS-1:0]        color;
  logic                         vld_out;
  logic                         rdy_out;
  logic [FX_TOTAL_BITS-1:0]     o_v0_x, o_v0_y, o_v0_z, o_v1_x, o_v1_y, o_v1_z;
  logic [FX_TOTAL_BITS-1:0]     o_v2_x, o_v2_y, o_v2_z;
  logic [COLOR_BITS-1:0]        color_out;
  logic [TILE_COLUMNS_BITS-1:0] tile_x;
  logic [TILE_ROWS_BITS-1:0]    tile_y;
  logic                         busy;

  tile_binner #(
    .TILE_SHIFT    (4),
    .NUM_TILE_COLS (40),
    .NUM_TILE_ROWS (30),
    .CULL_DEGEN    (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .vld_in    (vld_in),
    .rdy_in    (rdy_in),
    .v0_x      (v0_x),
    .v0_y      (v0_y),
    .v0_z      (v0_z),
    .v1_x      (v1_x),
    .v1_y      (v1_y),
    .v1_z      (v1_z),
    .v2_x      (v2_x),
    .v2_y      (v2_y),
    .v2_z      (v2_z),
    .color     (color),
    .vld_out   (vld_out),
    .rdy_out   (rdy_out),
    .o_v0_x    (o_v0_x),
    .o_v0_y    (o_v0_y),
    .o_v0_z    (o_v0_z),
    .o_v1_x    (o_v1_x),
    .o_v1_y    (o_v1_y),
    .o_v1_z    (o_v1_z),
    .o_v2_x    (o_v2_x),
    .o_v2_y    (o_v2_y),
    .o_v2_z    (o_v2_z),
    .color_out (color_out),
    .tile_x    (tile_x),
    .tile_y    (tile_y),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x0, y0, x1, y1, x2, y2;   // vertex positions in whole pixels
    int col;
    int stall;                    // cycles rdy_out is held low before each job
    int culled;
    int txmin, txmax, tymin, tymax;
    int jobs;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs [NVEC];

  int n_checks = 0;
  int n_errors = 0;

  logic [COLOR_BITS-1:0] exp_color;
  logic [143:0]          exp_verts;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [FX_TOTAL_BITS-1:0] fx(input int px);
    return FX_TOTAL_BITS'(px * 16);
  endfunction

  function automatic logic [143:0] dut_verts();
    return {o_v0_x, o_v0_y, o_v0_z, o_v1_x, o_v1_y, o_v1_z, o_v2_x, o_v2_y, o_v2_z};
  endfunction

  // Entered at a negedge; returns just after the accepting posedge.
  task automatic send(input vec_t v, input int idx);
    int w;
    v0_x = fx(v.x0); v0_y = fx(v.y0); v0_z = 16'h0100 + 16'(idx);
    v1_x = fx(v.x1); v1_y = fx(v.y1); v1_z = 16'h8000 + 16'(idx);
    v2_x = fx(v.x2); v2_y = fx(v.y2); v2_z = 16'h7f00 - 16'(idx);
    color = COLOR_BITS'(v.col);
    exp_color = COLOR_BITS'(v.col);
    exp_verts = {v0_x, v0_y, v0_z, v1_x, v1_y, v1_z, v2_x, v2_y, v2_z};
    vld_in = 1'b1;
    w = 0;
    while (!rdy_in && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("accept_ready", rdy_in, 1);
    @(posedge clk);
    #1 vld_in = 1'b0;
  endtask

  // Accept a triangle and check the two-cycle setup latency; ends at the
  // negedge following edge N+2.
  task automatic start(input vec_t v, input int idx);
    send(v, idx);
    @(negedge clk);
    check("setup_busy", busy, 1);
    check("setup_rdy_in_low", rdy_in, 0);
    @(negedge clk);
    check("setup_no_vld", vld_out, 0);
    @(negedge clk);
  endtask

  task automatic collect(input vec_t v);
    int seen;
    bit rose;
    seen = 0;
    if (v.culled != 0) begin
      check("cull_rdy_in", rdy_in, 1);
      check("cull_busy", busy, 0);
      rose = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (vld_out) rose = 1'b1;
        @(negedge clk);
      end
      check("cull_no_vld", rose, 0);
      return;
    end
    for (int ty = v.tymin; ty <= v.tymax; ty++) begin
      for (int tx = v.txmin; tx <= v.txmax; tx++) begin
        for (int s = 0; s < v.stall; s++) begin
          rdy_out = 1'b0;
          check("hold_vld", vld_out, 1);
          check("hold_tile", {tile_y, tile_x}, {TILE_ROWS_BITS'(ty), TILE_COLUMNS_BITS'(tx)});
          @(negedge clk);
        end
        rdy_out = 1'b1;
        check("job_vld", vld_out, 1);
        check("job_tile_x", tile_x, tx);
        check("job_tile_y", tile_y, ty);
        check("job_color", color_out, exp_color);
        check("job_verts", dut_verts(), exp_verts);
        if (vld_out) seen++;
        @(negedge clk);
      end
    end
    rdy_out = 1'b0;
    check("done_vld_low", vld_out, 0);
    check("done_rdy_in", rdy_in, 1);
    check("job_count", seen, v.jobs);
  endtask

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not reach summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit busy_seen;
    //            x0   y0   x1   y1   x2   y2  col st cul xmn xmx ymn ymx jobs
    vecs[0]  = '{   1,   1,   1,   5,   5,   1,  4, 0, 0,  0,  0,  0,  0,  1};
    vecs[1]  = '{   0,   0,   0,  31,  31,   0,  9, 0, 0,  0,  1,  0,  1,  4};
    vecs[2]  = '{   0,   0,   0,  31,  31,   0, 10, 3, 0,  0,  1,  0,  1,  4};
    vecs[3]  = '{ -40,  -5, -20,  -5, -30,  -1, 11, 0, 1,  0,  0,  0,  0,  0};
    vecs[4]  = '{   3,   3,   6,   6,   9,   9, 12, 0, 1,  0,  0,  0,  0,  0};
    vecs[5]  = '{ 600, 400, 700, 400, 600, 500, 13, 0, 0, 37, 39, 25, 29, 15};
    vecs[6]  = '{  16,  16,  31,  16,  16,  31, 14, 0, 0,  1,  1,  1,  1,  1};
    vecs[7]  = '{  15,   0,  16,   0,  15,   5, 15, 0, 0,  0,  1,  0,  0,  2};
    vecs[8]  = '{ -10, -10,  20, -10, -10,  20, 16, 1, 0,  0,  1,  0,  1,  4};
    vecs[9]  = '{ 700,  10, 720,  10, 700,  30, 17, 0, 1,  0,  0,  0,  0,  0};
    vecs[10] = '{  10, 500,  20, 500,  10, 520, 18, 0, 1,  0,  0,  0,  0,  0};
    vecs[11] = '{ 639, 479, 639, 470, 630, 479, 19, 0, 0, 39, 39, 29, 29,  1};

    rst_n = 1'b0; vld_in = 1'b0; rdy_out = 1'b0; color = '0;
    v0_x = '0; v0_y = '0; v0_z = '0; v1_x = '0; v1_y = '0; v1_z = '0;
    v2_x = '0; v2_y = '0; v2_z = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_rdy_in", rdy_in, 1);
    check("rst_vld_out", vld_out, 0);
    check("rst_busy", busy, 0);
    check("rst_tile", {tile_y, tile_x}, 0);
    check("rst_color", color_out, 0);
    check("rst_verts", dut_verts(), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven triangles
    for (int i = 0; i < NVEC; i++) begin
      start(vecs[i], i);
      collect(vecs[i]);
    end

    // Reset asserted during the third job of the four-tile triangle
    start(vecs[1], 20);
    rdy_out = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_tile", {tile_y, tile_x}, {TILE_ROWS_BITS'(1), TILE_COLUMNS_BITS'(0)});
    check("pre_rst_vld", vld_out, 1);
    rdy_out = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_vld", vld_out, 0);
    check("mid_rst_tile", {tile_y, tile_x}, 0);
    check("mid_rst_rdy_in", rdy_in, 1);
    check("mid_rst_color", color_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start(vecs[0], 21);
    collect(vecs[0]);

    // vld_in pulsed while the binner is emitting must not be latched
    start(vecs[7], 30);
    rdy_out = 1'b0;
    v0_x = fx(100);
    color = 24'd77;
    vld_in = 1'b1;
    @(negedge clk);
    vld_in = 1'b0;
    check("busy_ign_color", color_out, exp_color);
    check("busy_ign_verts", dut_verts(), exp_verts);
    check("busy_ign_tile", {tile_y, tile_x}, 0);
    collect(vecs[7]);
    busy_seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (busy || vld_out) busy_seen = 1'b1;
      @(negedge clk);
    end
    check("busy_ign_no_restart", busy_seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
